// File: rtl/periph_pkg.sv
// Shared definitions for memory-mapped peripheral slaves: register offsets,
// access-size encodings and the responder state encoding.
package periph_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  localparam logic [31:0] OFF_CTRL    = 32'h0000_0000;
  localparam logic [31:0] OFF_COUNT   = 32'h0000_0004;
  localparam logic [31:0] OFF_CMP     = 32'h0000_0008;
  localparam logic [31:0] OFF_STATUS  = 32'h0000_000C;
  localparam logic [31:0] OFF_SCRATCH = 32'h0000_0010;
  localparam logic [31:0] OFF_LAST    = 32'h0000_0013;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

endpackage

// File: rtl/periph_lane_merge.sv
// Byte-lane write merge: overlays unshifted write data onto an existing word
// according to access size and low address bits, and reports the lanes touched.
module periph_lane_merge
  import periph_pkg::*;
(
  input  logic [31:0] old_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  output logic [31:0] new_o,
  output logic [3:0]  mask_o
);

  logic [31:0] lane_data;

  always_comb begin
    mask_o    = 4'b0000;
    lane_data = wdata_i;
    case (size_i)
      SZ_B: begin
        mask_o    = 4'b0001 << addr_lo_i;
        lane_data = {4{wdata_i[7:0]}};
      end
      SZ_H: begin
        mask_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{wdata_i[15:0]}};
      end
      SZ_W: begin
        mask_o    = 4'b1111;
        lane_data = wdata_i;
      end
      default: begin
        mask_o    = 4'b0000;
        lane_data = wdata_i;
      end
    endcase
    for (int i = 0; i < 4; i++) begin
      new_o[8*i +: 8] = mask_o[i] ? lane_data[8*i +: 8] : old_i[8*i +: 8];
    end
  end

endmodule

// File: rtl/periph_timer_responder.sv
// Peripheral slave with a free-running compare timer, W1C status and scratch
// register; answers each request after WAIT_STATES cycles with a one-cycle Ack.
module periph_timer_responder
  import periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0200,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned CNT_W       = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        transEn,
  input  logic [31:0] PerAddr,
  input  logic [31:0] PerWData,
  input  logic        PerWrite,
  input  logic [1:0]  PerSize,
  output logic [31:0] PerRData,
  output logic        Ack,
  output logic        Busy,
  output logic        PerErr,
  output logic        Irq,
  output state_t      dbg_state_o
);

  // Handshake: the core raises transEn with stable request fields and holds it
  // until it sees Ack for one cycle; fields are captured on acceptance in IDLE.
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t      state_q;
  logic [3:0]  wcnt_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        write_q;
  logic [1:0]  size_q;
  logic        ack_q;
  logic        err_q;
  logic [31:0] rdata_q;

  logic [1:0]       ctrl_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] cmp_q;
  logic             status_q;
  logic [31:0]      scratch_q;
  logic             irq_q;

  logic [31:0] dec_addr;
  logic [1:0]  dec_size;
  logic [31:0] dec_off;
  logic [31:0] dec_word;
  logic        dec_err;
  logic [31:0] rd_word;
  logic [31:0] merged;
  logic [3:0]  wmask;
  logic        commit;
  logic        wr_ctrl, wr_count, wr_cmp, wr_status, wr_scratch;
  logic        match;
  logic        unused_lanes;

  // In IDLE the decode looks at the live request so a zero-wait access can
  // register its response on the acceptance edge; afterwards it uses the latch.
  always_comb begin
    dec_addr = (state_q == S_IDLE) ? PerAddr : addr_q;
    dec_size = (state_q == S_IDLE) ? PerSize : size_q;
    dec_off  = dec_addr - BASE_ADDR;
    dec_word = {dec_off[31:2], 2'b00};
    dec_err  = (dec_addr < BASE_ADDR) || (dec_off > OFF_LAST) ||
               (dec_size == 2'b11) ||
               ((dec_size == SZ_H) && dec_addr[0]) ||
               ((dec_size == SZ_W) && (dec_addr[1:0] != 2'b00));
    case (dec_word)
      OFF_CTRL:    rd_word = {30'b0, ctrl_q};
      OFF_COUNT:   rd_word = 32'(count_q);
      OFF_CMP:     rd_word = 32'(cmp_q);
      OFF_STATUS:  rd_word = {31'b0, status_q};
      OFF_SCRATCH: rd_word = scratch_q;
      default:     rd_word = 32'h0;
    endcase
    commit     = (state_q == S_ACK) && write_q && !dec_err;
    wr_ctrl    = commit && (dec_word == OFF_CTRL);
    wr_count   = commit && (dec_word == OFF_COUNT);
    wr_cmp     = commit && (dec_word == OFF_CMP);
    wr_status  = commit && (dec_word == OFF_STATUS);
    wr_scratch = commit && (dec_word == OFF_SCRATCH);
    match      = ctrl_q[0] && (count_q == cmp_q);
  end

  periph_lane_merge u_merge (
    .old_i     (rd_word),
    .wdata_i   (wdata_q),
    .size_i    (size_q),
    .addr_lo_i (addr_q[1:0]),
    .new_o     (merged),
    .mask_o    (wmask)
  );

  assign unused_lanes = ^wmask[3:1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wcnt_q  <= 4'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      write_q <= 1'b0;
      size_q  <= 2'b00;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (transEn) begin
            addr_q  <= PerAddr;
            wdata_q <= PerWData;
            write_q <= PerWrite;
            size_q  <= PerSize;
            if (WAIT_STATES == 0) begin
              state_q <= S_ACK;
              ack_q   <= 1'b1;
              err_q   <= dec_err;
              rdata_q <= dec_err ? 32'h0 : rd_word;
            end else begin
              state_q <= S_WAIT;
              wcnt_q  <= WAIT_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (wcnt_q == 4'd0) begin
            state_q <= S_ACK;
            ack_q   <= 1'b1;
            err_q   <= dec_err;
            rdata_q <= dec_err ? 32'h0 : rd_word;
          end else begin
            wcnt_q <= wcnt_q - 4'd1;
          end
        end
        S_ACK: begin
          state_q <= S_IDLE;
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
          rdata_q <= 32'h0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Bus write to COUNT overrides the timer; a match set overrides a W1C clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q    <= 2'b00;
      count_q   <= '0;
      cmp_q     <= '0;
      status_q  <= 1'b0;
      scratch_q <= 32'h0;
      irq_q     <= 1'b0;
    end else begin
      if (wr_ctrl)    ctrl_q    <= merged[1:0];
      if (wr_cmp)     cmp_q     <= merged[CNT_W-1:0];
      if (wr_scratch) scratch_q <= merged;
      if (wr_count)       count_q <= merged[CNT_W-1:0];
      else if (match)     count_q <= '0;
      else if (ctrl_q[0]) count_q <= count_q + CNT_ONE;
      if (match)
        status_q <= 1'b1;
      else if (wr_status && wmask[0] && merged[0])
        status_q <= 1'b0;
      irq_q <= status_q & ctrl_q[1];
    end
  end

  assign PerRData    = rdata_q;
  assign Ack         = ack_q;
  assign PerErr      = err_q;
  assign Busy        = transEn & ~ack_q;
  assign Irq         = irq_q;
  assign dbg_state_o = state_q;

endmodule
